mult_par_iter: RTL and testbench
================================

Name: mult_par_iter

Overview:
- Parametrised iterative multiplier with parity-protected operands and a req/ack handshake.
- Successor to the fixed-width parity multiplier. Adds configurable operand width and bits-per-cycle (radix), a busy flag, and optional signed mode.
- Sits behind the stimulus/driver layer. Reset, correct input and incorrect-parity (A, B, both) operations all exercise it directly.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of RADIX_BITS.
- RADIX_BITS, 1, operand-B bits consumed per CALC cycle; legal values 1, 2, 4. N = WIDTH/RADIX_BITS iterations.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req  in  1  request; sampled only in IDLE
- arg_a  in  WIDTH  operand A
- arg_a_parity  in  1  even-parity bit of arg_a
- arg_b  in  WIDTH  operand B
- arg_b_parity  in  1  even-parity bit of arg_b
- ack  out  1  one-cycle pulse: operands accepted
- busy  out  1  high from acceptance until the cycle after result_rdy
- result  out  2*WIDTH  product, held until next acceptance
- result_parity  out  1  even-parity bit of result
- result_rdy  out  1  one-cycle pulse: result valid
- arg_parity_error  out  1  set with result_rdy when either operand failed parity; held until next acceptance

Behaviour:
- Reset: synchronous, active-low. rst_n=0 at an edge forces state IDLE. All outputs 0; accumulator and counter 0.
- Reset mid-operation aborts the computation. No result_rdy is produced for the aborted request.
- Parity rule: a parity bit is correct when it equals the XOR-reduce of its data word.
- States: IDLE, CALC, ERR, DONE.
- IDLE:
  - req=1 at edge t captures arg_a, arg_b and both parity bits; ack=1 during cycle t+1.
  - Clears result, result_parity and arg_parity_error.
  - Any parity mismatch -> ERR; otherwise -> CALC with counter=N-1.
  - req=0 stays in IDLE.
- CALC:
  - One shift-add step per cycle: partial product arg_a * (next RADIX_BITS of B, LSB first), added into a 2*WIDTH accumulator.
  - Lasts exactly N cycles (t+1..t+N); the counter reaching 0 -> DONE.
- DONE (cycle t+N+1): result=accumulator, result_parity=^result, result_rdy=1 -> IDLE.
- ERR (cycle t+1, coincides with ack) -> DONE-equivalent at t+2: result=0, result_parity=0, arg_parity_error=1, result_rdy=1 -> IDLE.
- busy=1 from cycle t+1 through the result_rdy cycle.
- req asserted while busy is ignored, with no ack and no queuing. Back-to-back: req high in the result_rdy cycle is not accepted. The earliest acceptance is the following edge, while in IDLE.
- Latency: ack at t+1; result_rdy at t+N+1 for the correct path, t+2 for the error path.
- Arithmetic: unsigned by default. Full 2*WIDTH product with no truncation or overflow possible.

Optional Feature:
- Macro: MULT_PAR_ITER_SIGNED_EN.
- Defined:
  - Adds input port signed_mode (1 bit), captured with req.
  - signed_mode=1 treats operands as two's complement. The top RADIX_BITS digit of B is signed (subtracted) and A is sign-extended in the accumulator. result is the signed 2*WIDTH product.
  - Latency is unchanged.
- Undefined: port absent; unsigned only.

Decomposition:
- Shared package (mult_pkg) holds:
  - the state enum mult_state_t {IDLE, CALC, ERR, DONE};
  - the operation enum extended with SIGNED_INPUT;
  - function even_parity(input logic [] data), used by both DUT and bench;
  - localparam defaults for WIDTH/RADIX_BITS.
- One sub-module is natural: mult_par_chk (combinational parity check of both operands, producing err_a, err_b).

Test Plan:
- Reset: rst_n=0 for 2 cycles mid-CALC -> all outputs 0 and no result_rdy. The next req is accepted normally.
- Correct input, WIDTH=16, RADIX_BITS=1: A=3, pA=0, B=5, pB=0 at t -> ack at t+1; result=15, result_parity=0, result_rdy at t+17; busy high t+1..t+17.
- Max operands: A=B=0xFFFF, parities 0 -> result=0xFFFE0001, result_parity=0, arg_parity_error=0.
- Parity errors: A=3 with pA=1 -> ack t+1, result_rdy t+2, result=0, arg_parity_error=1. Repeat for B-only and both-wrong; each gives the same response.
- Radix/busy: RADIX_BITS=4, A=0x1234, B=0x0010 -> result=0x00012340 at t+5. A second req at t+2 gets no ack and causes no state change.
- Signed (MULT_PAR_ITER_SIGNED_EN, WIDTH=16): signed_mode=1, A=0xFFFE, pA=1, B=3, pB=0 -> result=0xFFFFFFFA, result_parity=0.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the parity-protected iterative multiplier.
// No logic state; pure declarations.
// No flow control.
package mult_pkg;

  localparam int WIDTH_DEF      = 16;
  localparam int RADIX_BITS_DEF = 1;

  // Widest word the parity helper accepts; callers zero-extend (parity-neutral).
  localparam int PAR_MAX_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ERR,
    DONE
  } mult_state_t;

  // Operation classes driven by the stimulus layer.
  typedef enum logic [2:0] {
    RST_INPUT,
    CORR_INPUT,
    INCORRECT_A,
    INCORRECT_B,
    INCORRECT_AB,
    SIGNED_INPUT
  } mult_op_t;

  // Even parity: the parity bit equals the XOR-reduce of the data word.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/mult_par_chk.sv
// Combinational parity check of both operands.
// Latency: 0 cycles (pure combinational).
// No flow control; results are valid whenever the inputs are.
module mult_par_chk import mult_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] arg_a,
  input  logic             arg_a_parity,
  input  logic [WIDTH-1:0] arg_b,
  input  logic             arg_b_parity,
  output logic             err_a,
  output logic             err_b
);

  assign err_a = (arg_a_parity != even_parity(PAR_MAX_W'(arg_a)));
  assign err_b = (arg_b_parity != even_parity(PAR_MAX_W'(arg_b)));

endmodule

// File: rtl/mult_par_iter.sv
// Iterative shift-add multiplier, RADIX_BITS of B per cycle, parity-checked operands.
// Latency: ack at t+1, result_rdy at t+N+1 (good parity) or t+2 (parity error).
// req is ignored while busy; no queuing. Optional signed mode: MULT_PAR_ITER_SIGNED_EN.
module mult_par_iter import mult_pkg::*; #(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int RADIX_BITS = RADIX_BITS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
`ifdef MULT_PAR_ITER_SIGNED_EN
  input  logic               signed_mode,
`endif
  input  logic [WIDTH-1:0]   arg_a,
  input  logic               arg_a_parity,
  input  logic [WIDTH-1:0]   arg_b,
  input  logic               arg_b_parity,
  output logic               ack,
  output logic               busy,
  output logic [2*WIDTH-1:0] result,
  output logic               result_parity,
  output logic               result_rdy,
  output logic               arg_parity_error
);

  localparam int N     = WIDTH / RADIX_BITS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int PW    = 2 * WIDTH;

  mult_state_t       state_q, state_d;
  logic [PW-1:0]     a_q, a_d;          // A, extended and pre-shifted to the current digit
  logic [WIDTH-1:0]  b_q, b_d;          // remaining digits of B, LSB first
  logic [CNT_W-1:0]  cnt_q, cnt_d;      // digits left after the current one
  logic [PW-1:0]     acc_q, acc_d;
  logic              sgn_q, sgn_d;
  logic [PW-1:0]     result_q, result_d;
  logic              rpar_q, rpar_d;
  logic              rdy_q, rdy_d;
  logic              ack_q, ack_d;
  logic              perr_q, perr_d;

  logic              err_a, err_b;
  logic              sgn_in;
  logic [PW-1:0]     a_ext;
  logic [RADIX_BITS-1:0] dig;
  logic [PW-1:0]     dig_ext;
  logic              top_neg;
  logic [PW-1:0]     pp;
  logic [PW-1:0]     acc_sum;

`ifdef MULT_PAR_ITER_SIGNED_EN
  assign sgn_in = signed_mode;
`else
  assign sgn_in = 1'b0;
`endif

  mult_par_chk #(.WIDTH(WIDTH)) u_chk (
    .arg_a        (arg_a),
    .arg_a_parity (arg_a_parity),
    .arg_b        (arg_b),
    .arg_b_parity (arg_b_parity),
    .err_a        (err_a),
    .err_b        (err_b)
  );

  // Sign- or zero-extend A so two's-complement wraparound in the accumulator is exact.
  assign a_ext   = sgn_in ? {{WIDTH{arg_a[WIDTH-1]}}, arg_a} : {{WIDTH{1'b0}}, arg_a};
  assign dig     = b_q[RADIX_BITS-1:0];
  assign dig_ext = {{(PW-RADIX_BITS){1'b0}}, dig};
  // The most significant digit of B carries negative weight in signed mode.
  assign top_neg = sgn_q && (cnt_q == '0) && dig[RADIX_BITS-1];

  // Partial product of A and the current digit; signed top digit is dig - 2^RADIX_BITS.
  always_comb begin
    pp = a_q * dig_ext;
    if (top_neg) begin
      pp = pp - (a_q << RADIX_BITS);
    end
  end

  assign acc_sum = acc_q + pp;

  // Next-state and output decode for the IDLE/CALC/ERR/DONE sequence.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sgn_d    = sgn_q;
    result_d = result_q;
    rpar_d   = rpar_q;
    perr_d   = perr_q;
    rdy_d    = 1'b0;
    ack_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          ack_d    = 1'b1;
          result_d = '0;
          rpar_d   = 1'b0;
          perr_d   = 1'b0;
          acc_d    = '0;
          a_d      = a_ext;
          b_d      = arg_b;
          sgn_d    = sgn_in;
          cnt_d    = CNT_W'(N - 1);
          state_d  = (err_a || err_b) ? ERR : CALC;
        end
      end
      CALC: begin
        acc_d = acc_sum;
        a_d   = a_q << RADIX_BITS;
        b_d   = b_q >> RADIX_BITS;
        if (cnt_q == '0) begin
          state_d  = DONE;
          result_d = acc_sum;
          rpar_d   = even_parity(PAR_MAX_W'(acc_sum));
          rdy_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ERR: begin
        state_d  = DONE;
        result_d = '0;
        rpar_d   = 1'b0;
        perr_d   = 1'b1;
        rdy_d    = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      sgn_q    <= 1'b0;
      result_q <= '0;
      rpar_q   <= 1'b0;
      rdy_q    <= 1'b0;
      ack_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sgn_q    <= sgn_d;
      result_q <= result_d;
      rpar_q   <= rpar_d;
      rdy_q    <= rdy_d;
      ack_q    <= ack_d;
      perr_q   <= perr_d;
    end
  end

  assign ack              = ack_q;
  assign busy             = (state_q != IDLE);
  assign result           = result_q;
  assign result_parity    = rpar_q;
  assign result_rdy       = rdy_q;
  assign arg_parity_error = perr_q;

endmodule

// File: tb/tb_mult_par_iter.sv
// Scoreboard bench for mult_par_iter: one instance at RADIX_BITS=1, one at RADIX_BITS=4.
// Expected results are queued when a request is driven and compared on result_rdy.
// Signed-mode cases are built only when MULT_PAR_ITER_SIGNED_EN is defined.
`timescale 1ns/1ps
module tb_mult_par_iter;
  import mult_pkg::*;

  localparam int W = 16;

  typedef struct {
    logic [2*W-1:0] res;
    logic           par;
    logic           perr;
    int             lat;
    int             stamp;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [W-1:0]   arg_a, arg_b;
  logic           arg_a_parity, arg_b_parity;
  logic           req  [2];
  logic           ack  [2];
  logic           busy [2];
  logic           rdy  [2];
  logic           rpar [2];
  logic           perr [2];
  logic [2*W-1:0] res  [2];
`ifdef MULT_PAR_ITER_SIGNED_EN
  logic           signed_mode;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q [2][$];

  always @(posedge clk) cyc <= cyc + 1;

  mult_par_iter #(.WIDTH(W), .RADIX_BITS(1)) u_dut_r1 (
    .clk(clk), .rst_n(rst_n), .req(req[0]),
`ifdef MULT_PAR_ITER_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .arg_a(arg_a), .arg_a_parity(arg_a_parity), .arg_b(arg_b), .arg_b_parity(arg_b_parity),
    .ack(ack[0]), .busy(busy[0]), .result(res[0]), .result_parity(rpar[0]),
    .result_rdy(rdy[0]), .arg_parity_error(perr[0])
  );

  mult_par_iter #(.WIDTH(W), .RADIX_BITS(4)) u_dut_r4 (
    .clk(clk), .rst_n(rst_n), .req(req[1]),
`ifdef MULT_PAR_ITER_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .arg_a(arg_a), .arg_a_parity(arg_a_parity), .arg_b(arg_b), .arg_b_parity(arg_b_parity),
    .ack(ack[1]), .busy(busy[1]), .result(res[1]), .result_parity(rpar[1]),
    .result_rdy(rdy[1]), .arg_parity_error(perr[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Compare every result_rdy pulse against the oldest queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (rdy[i]) begin
        if (q[i].size() == 0) begin
          chk($sformatf("d%0d_unexpected_rdy", i), rdy[i], 1'b0);
        end else begin
          e = q[i].pop_front();
          chk($sformatf("d%0d_result", i), res[i], e.res);
          chk($sformatf("d%0d_result_parity", i), rpar[i], e.par);
          chk($sformatf("d%0d_parity_error", i), perr[i], e.perr);
          chk($sformatf("d%0d_latency", i), cyc - e.stamp, e.lat);
          chk($sformatf("d%0d_busy_at_rdy", i), busy[i], 1'b1);
        end
      end
    end
  end

  task automatic build(input int d, input mult_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output exp_t e, output logic pa, output logic pb);
    longint ua, ub;
    int     sa, sb;
    pa = even_parity(PAR_MAX_W'(a));
    pb = even_parity(PAR_MAX_W'(b));
    if (op == INCORRECT_A || op == INCORRECT_AB) pa = ~pa;
    if (op == INCORRECT_B || op == INCORRECT_AB) pb = ~pb;
    if (op == INCORRECT_A || op == INCORRECT_B || op == INCORRECT_AB) begin
      e.res  = '0;
      e.par  = 1'b0;
      e.perr = 1'b1;
      e.lat  = 2;
    end else begin
      if (op == SIGNED_INPUT) begin
        sa    = $signed(a);
        sb    = $signed(b);
        e.res = 32'(sa * sb);
      end else begin
        ua    = longint'(a);
        ub    = longint'(b);
        e.res = 32'(ua * ub);
      end
      e.par  = ^e.res;
      e.perr = 1'b0;
      e.lat  = ((d == 0) ? W : W / 4) + 1;
    end
    e.stamp = 0;
  endtask

  task automatic drive_args(input mult_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic pa, input logic pb);
    arg_a        = a;
    arg_b        = b;
    arg_a_parity = pa;
    arg_b_parity = pb;
`ifdef MULT_PAR_ITER_SIGNED_EN
    signed_mode  = (op == SIGNED_INPUT);
`endif
  endtask

  // Present one request for exactly one edge, queue the expectation, check ack.
  task automatic do_op(input int d, input mult_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic pa, pb;
    build(d, op, a, b, e, pa, pb);
    @(posedge clk); #1;
    drive_args(op, a, b, pa, pb);
    req[d]  = 1'b1;
    e.stamp = cyc;
    q[d].push_back(e);
    @(posedge clk); #1;
    req[d] = 1'b0;
    chk($sformatf("d%0d_ack", d), ack[d], 1'b1);
    chk($sformatf("d%0d_busy_at_ack", d), busy[d], 1'b1);
  endtask

  task automatic wait_done(input int d);
    int k = 0;
    while (q[d].size() != 0 && k < 60) begin
      @(posedge clk);
      k++;
    end
    chk($sformatf("d%0d_done_timeout", d), q[d].size(), 0);
    @(negedge clk);
    chk($sformatf("d%0d_busy_after", d), busy[d], 1'b0);
  endtask

  task automatic chk_outputs_zero(input int d, input string pfx);
    chk({pfx, "_ack"}, ack[d], 1'b0);
    chk({pfx, "_busy"}, busy[d], 1'b0);
    chk({pfx, "_rdy"}, rdy[d], 1'b0);
    chk({pfx, "_result"}, res[d], '0);
    chk({pfx, "_rpar"}, rpar[d], 1'b0);
    chk({pfx, "_perr"}, perr[d], 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t     e;
    logic     pa, pb;
    mult_op_t ops [4];
    int       d, k;
    ops[0] = CORR_INPUT; ops[1] = INCORRECT_A; ops[2] = INCORRECT_B; ops[3] = INCORRECT_AB;

    rst_n = 1'b0;
    req[0] = 1'b0; req[1] = 1'b0;
    drive_args(CORR_INPUT, '0, '0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero(0, "rst_d0");
    chk_outputs_zero(1, "rst_d1");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic products and the all-ones boundary.
    do_op(0, CORR_INPUT, 16'd3, 16'd5);        wait_done(0);
    do_op(0, CORR_INPUT, 16'hFFFF, 16'hFFFF);  wait_done(0);

    // Parity errors on A, B and both.
    do_op(0, INCORRECT_A, 16'd3, 16'd5);       wait_done(0);
    do_op(0, INCORRECT_B, 16'd3, 16'd5);       wait_done(0);
    do_op(0, INCORRECT_AB, 16'd3, 16'd5);      wait_done(0);

    // Radix-4 product with a second request landing mid-calculation.
    do_op(1, CORR_INPUT, 16'h1234, 16'h0010);
    drive_args(CORR_INPUT, 16'hAAAA, 16'h5555, 1'b0, 1'b0);
    req[1] = 1'b1;
    @(posedge clk); #1;
    req[1] = 1'b0;
    chk("d1_ack_while_busy", ack[1], 1'b0);
    wait_done(1);
    do_op(1, CORR_INPUT, 16'hFFFF, 16'hFFFF);  wait_done(1);
    do_op(1, INCORRECT_B, 16'h00FF, 16'h0101); wait_done(1);

    // Back-to-back: req raised in the result_rdy cycle is taken one edge later.
    do_op(1, CORR_INPUT, 16'd7, 16'd9);
    k = 0;
    while (k < 20) begin
      @(posedge clk); #1;
      k++;
      if (rdy[1]) break;
    end
    chk("d1_b2b_rdy_seen", rdy[1], 1'b1);
    build(1, CORR_INPUT, 16'h0102, 16'h0304, e, pa, pb);
    drive_args(CORR_INPUT, 16'h0102, 16'h0304, pa, pb);
    req[1] = 1'b1;
    @(posedge clk); #1;
    chk("d1_b2b_no_ack_in_rdy", ack[1], 1'b0);
    e.stamp = cyc;
    q[1].push_back(e);
    @(posedge clk); #1;
    req[1] = 1'b0;
    chk("d1_b2b_ack", ack[1], 1'b1);
    wait_done(1);

    // Reset in the middle of a calculation: abort, no result, clean outputs.
    build(0, CORR_INPUT, 16'd11, 16'd13, e, pa, pb);
    @(posedge clk); #1;
    drive_args(CORR_INPUT, 16'd11, 16'd13, pa, pb);
    req[0] = 1'b1;
    @(posedge clk); #1;
    req[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk_outputs_zero(0, "midrst_d0");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    do_op(0, CORR_INPUT, 16'd11, 16'd13);      wait_done(0);

    // Random mix across both instances.
    for (int i = 0; i < 10; i++) begin
      d = $urandom_range(0, 1);
      do_op(d, ops[$urandom_range(0, 3)], 16'($urandom), 16'($urandom));
      wait_done(d);
    end

`ifdef MULT_PAR_ITER_SIGNED_EN
    do_op(0, SIGNED_INPUT, 16'hFFFE, 16'd3);   wait_done(0);
    do_op(1, SIGNED_INPUT, 16'hFFFD, 16'hFFFB); wait_done(1);
    do_op(1, SIGNED_INPUT, 16'h7FFF, 16'h8000); wait_done(1);
    do_op(0, SIGNED_INPUT, 16'h8000, 16'h8000); wait_done(0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
